// File: rtl/uart_status_tx_if.sv
// Byte-level handshake between the status transmitter and the shared uart.
// The transmitter is the master: it loads bytes and watches is_transmitting.
interface uart_status_tx_if;
    logic       transmit;
    logic [7:0] tx_byte;
    logic       is_transmitting;

    modport master (
        output transmit,
        output tx_byte,
        input  is_transmitting
    );

    modport slave (
        input  transmit,
        input  tx_byte,
        output is_transmitting
    );
endinterface

// File: rtl/uart_status_tx.sv
// Emits a 16-byte ASCII status frame "S:dddd T:hto F\r\n" through the shared uart
// whenever score, countdown or the start/over flags change.
module uart_status_tx #(
    parameter int CNT_W  = 10,
    parameter int CD_MAX = 999
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic [15:0]          score,
    input  logic [CNT_W-1:0]     count_down,
    input  logic                 start,
    input  logic                 over,
    uart_status_tx_if.master     uart,
    output logic                 busy
);

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        LOAD,
        PULSE,
        WAIT_HI,
        WAIT_LO
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      prev_score_q, prev_score_d;
    logic [CNT_W-1:0] prev_cd_q, prev_cd_d;
    logic             prev_start_q, prev_start_d;
    logic             prev_over_q, prev_over_d;
    logic             pending_q, pending_d;
    logic             busy_q, busy_d;
    logic [15:0]      snap_score_q, snap_score_d;
    logic [7:0]       flag_q, flag_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [3:0]       hund_q, hund_d;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       ones_q, ones_d;
    logic [3:0]       idx_q, idx_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic             transmit;
    logic             trigger;
    logic [CNT_W-1:0] cd_sat;
    logic [7:0]       cur_byte;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] dec_char(input logic [3:0] n);
        return 8'h30 + {4'h0, n};
    endfunction

    assign trigger = (score != prev_score_q) || (count_down != prev_cd_q) ||
                     (start != prev_start_q) || (over != prev_over_q);
    assign cd_sat  = (count_down > CNT_W'(CD_MAX)) ? CNT_W'(CD_MAX) : count_down;

    always_comb begin
        cur_byte = 8'h20;
        case (idx_q)
            4'd0:    cur_byte = 8'h53;
            4'd1:    cur_byte = 8'h3A;
            4'd2:    cur_byte = hex_char(snap_score_q[15:12]);
            4'd3:    cur_byte = hex_char(snap_score_q[11:8]);
            4'd4:    cur_byte = hex_char(snap_score_q[7:4]);
            4'd5:    cur_byte = hex_char(snap_score_q[3:0]);
            4'd6:    cur_byte = 8'h20;
            4'd7:    cur_byte = 8'h54;
            4'd8:    cur_byte = 8'h3A;
            4'd9:    cur_byte = dec_char(hund_q);
            4'd10:   cur_byte = dec_char(tens_q);
            4'd11:   cur_byte = dec_char(ones_q);
            4'd12:   cur_byte = 8'h20;
            4'd13:   cur_byte = flag_q;
            4'd14:   cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        snap_score_d = snap_score_q;
        flag_d       = flag_q;
        rem_d        = rem_q;
        hund_d       = hund_q;
        tens_d       = tens_q;
        ones_d       = ones_q;
        idx_d        = idx_q;
        tx_byte_d    = tx_byte_q;
        transmit     = 1'b0;
        prev_score_d = score;
        prev_cd_d    = count_down;
        prev_start_d = start;
        prev_over_d  = over;

        // Pending coalesces any number of changes into one follow-up frame.
        pending_d = pending_q;
        if (!en) begin
            pending_d = 1'b0;
        end else if (trigger) begin
            pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (en && (trigger || pending_q)) begin
                    snap_score_d = score;
                    flag_d       = over ? 8'h4F : (start ? 8'h50 : 8'h49);
                    rem_d        = cd_sat;
                    hund_d       = 4'd0;
                    tens_d       = 4'd0;
                    ones_d       = 4'd0;
                    pending_d    = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = CONV;
                end
            end
            CONV: begin
                if (rem_q >= CNT_W'(100)) begin
                    rem_d  = rem_q - CNT_W'(100);
                    hund_d = hund_q + 4'd1;
                end else if (rem_q >= CNT_W'(10)) begin
                    rem_d  = rem_q - CNT_W'(10);
                    tens_d = tens_q + 4'd1;
                end else begin
                    ones_d  = rem_q[3:0];
                    idx_d   = 4'd0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                tx_byte_d = cur_byte;
                state_d   = PULSE;
            end
            PULSE: begin
                if (!uart.is_transmitting) begin
                    transmit = 1'b1;
                    state_d  = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (uart.is_transmitting) begin
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!uart.is_transmitting) begin
                    if (idx_q == 4'd15) begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Shadows keep tracking through reset so releasing reset alone sends nothing.
    always_ff @(posedge clk) begin
        prev_score_q <= prev_score_d;
        prev_cd_q    <= prev_cd_d;
        prev_start_q <= prev_start_d;
        prev_over_q  <= prev_over_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            pending_q    <= 1'b0;
            busy_q       <= 1'b0;
            snap_score_q <= 16'h0000;
            flag_q       <= 8'h00;
            rem_q        <= '0;
            hund_q       <= 4'd0;
            tens_q       <= 4'd0;
            ones_q       <= 4'd0;
            idx_q        <= 4'd0;
            tx_byte_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            busy_q       <= busy_d;
            snap_score_q <= snap_score_d;
            flag_q       <= flag_d;
            rem_q        <= rem_d;
            hund_q       <= hund_d;
            tens_q       <= tens_d;
            ones_q       <= ones_d;
            idx_q        <= idx_d;
            tx_byte_q    <= tx_byte_d;
        end
    end

    assign uart.transmit = transmit;
    assign uart.tx_byte  = tx_byte_q;
    assign busy          = busy_q;

endmodule
